axi_line_master: RTL



---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_beat_cnt.sv | 44 ++++
 rtl/axi_line_master.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
//   Shared AXI4 encodings and the FSM state type for axi_line_master.
//   Contents:
//     BURST_INCR - INCR burst encoding for arburst/awburst
//     RESP_OKAY  - OKAY response encoding for rresp/bresp
//     SIZE_8B    - 8-byte beat size for arsize/awsize
//     state_e    - line master FSM states
// -----------------------------------------------------------------------------
package axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_8B    = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B
  } state_e;

endpackage

// File: rtl/axi_beat_cnt.sv
// -----------------------------------------------------------------------------
// axi_beat_cnt
//   8-bit beat counter shared by the read and write data phases.
//   Ports:
//     clk     in  clock
//     rst_n   in  synchronous active-low reset
//     clr     in  clear counter to 0 (priority over inc)
//     inc     in  advance by one beat
//     is_last out counter equals LINE_BEATS-1
// -----------------------------------------------------------------------------
module axi_beat_cnt #(
  parameter int LINE_BEATS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic is_last
);

  localparam logic [7:0] LAST_IDX = 8'(LINE_BEATS - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/axi_line_master.sv
// -----------------------------------------------------------------------------
// axi_line_master
//   AXI4 master turning cache-line refill / writeback requests into single
//   INCR bursts of LINE_BEATS x 8-byte beats. One transaction in flight.
//
//   Ports:
//     aclk, aresetn                 clock, synchronous active-low reset
//     req_*                         line request from the cache front end
//     wbeat_*                       writeback beats from the front end
//     rbeat_*                       refill beats to the front end
//     done, err                     one-cycle completion / error pulses
//     ar*, r*, aw*, w*, b*          AXI4 master channels
//
//   Optional build macro:
//     AXI_LINE_MASTER_TIMEOUT_EN    adds a 16-bit watchdog; after TIMEOUT_CYC
//                                   cycles without a handshake outside IDLE the
//                                   transaction is abandoned with an err pulse.
// -----------------------------------------------------------------------------
module axi_line_master
  import axi_pkg::*;
#(
  parameter int         LINE_BEATS  = 4,
  parameter int         ADDR_W      = 32,
  parameter int         DATA_W      = 64,
  parameter logic [3:0] AXI_ID      = 4'd0,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_W-1:0]     req_addr,
  // writeback beats
  input  logic                  wbeat_valid,
  output logic                  wbeat_ready,
  input  logic [DATA_W-1:0]     wbeat_data,
  input  logic [DATA_W/8-1:0]   wbeat_strb,
  // refill beats
  output logic                  rbeat_valid,
  input  logic                  rbeat_ready,
  output logic [DATA_W-1:0]     rbeat_data,
  output logic                  rbeat_last,
  // status
  output logic                  done,
  output logic                  err,
  // AR
  output logic [ADDR_W-1:0]     araddr,
  output logic [3:0]            arid,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic                  arvalid,
  input  logic                  arready,
  // R
  input  logic [3:0]            rid,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  // AW
  output logic [ADDR_W-1:0]     awaddr,
  output logic [3:0]            awid,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  awvalid,
  input  logic                  awready,
  // W
  output logic [3:0]            wid,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  // B
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  // constant sideband
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot
);

  // Byte offset bits inside one line; these are cleared on the burst address.
  localparam int         OFF_W     = $clog2(LINE_BEATS * 8);
  localparam logic [7:0] BURST_LEN = 8'(LINE_BEATS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                arvalid_q, arvalid_d;
  logic                awvalid_q, awvalid_d;
  logic                bready_q, bready_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                beat_last;
  logic                r_hs, w_hs;
  logic                timeout;

  // Beat handshakes as seen on the AXI side; front-end handshakes coincide
  // because ready/valid are forwarded combinationally.
  assign r_hs = (state_q == ST_R) & rvalid & rbeat_ready;
  assign w_hs = (state_q == ST_W) & wbeat_valid & wready;

  axi_beat_cnt #(
    .LINE_BEATS (LINE_BEATS)
  ) u_beat_cnt (
    .clk     (aclk),
    .rst_n   (aresetn),
    .clr     (state_q == ST_IDLE),
    .inc     (r_hs | w_hs),
    .is_last (beat_last)
  );

`ifdef AXI_LINE_MASTER_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        any_hs;

  assign any_hs = (arvalid_q & arready) | r_hs | (awvalid_q & awready) |
                  w_hs | (bready_q & bvalid);

  always_comb begin
    wd_d    = wd_q;
    timeout = 1'b0;
    if (state_q == ST_IDLE || any_hs) begin
      wd_d = '0;
    end else if (wd_q == 16'(TIMEOUT_CYC - 1)) begin
      // Fires on the TIMEOUT_CYC-th stalled cycle so err lands exactly
      // TIMEOUT_CYC cycles after the stall began.
      timeout = 1'b1;
      wd_d    = '0;
    end else begin
      wd_d = wd_q + 16'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    arvalid_d = arvalid_q;
    awvalid_d = awvalid_q;
    bready_d  = bready_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          if (req_wr) begin
            state_d   = ST_AW;
            awvalid_d = 1'b1;
          end else begin
            state_d   = ST_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (r_hs) begin
          // A bad response flags err but the burst keeps going.
          if (rresp != RESP_OKAY) err_d = 1'b1;
          if (beat_last) begin
            if (rlast) done_d = 1'b1;
            else       err_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (rlast) begin
            // Slave ended the burst early: abandon the line.
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_AW: begin
        if (awready) begin
          awvalid_d = 1'b0;
          state_d   = ST_W;
        end
      end
      ST_W: begin
        if (w_hs && beat_last) begin
          bready_d = 1'b1;
          state_d  = ST_B;
        end
      end
      ST_B: begin
        if (bvalid) begin
          done_d   = 1'b1;
          err_d    = (bresp != RESP_OKAY);
          bready_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d   = ST_IDLE;
      arvalid_d = 1'b0;
      awvalid_d = 1'b0;
      bready_d  = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      bready_q  <= bready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign done        = done_q;
  assign err         = err_q;

  assign araddr      = addr_q;
  assign arid        = AXI_ID;
  assign arlen       = BURST_LEN;
  assign arsize      = SIZE_8B;
  assign arburst     = BURST_INCR;
  assign arvalid     = arvalid_q;

  assign rready      = (state_q == ST_R) & rbeat_ready;
  assign rbeat_valid = (state_q == ST_R) & rvalid;
  assign rbeat_data  = rdata;
  assign rbeat_last  = rlast;

  assign awaddr      = addr_q;
  assign awid        = AXI_ID;
  assign awlen       = BURST_LEN;
  assign awsize      = SIZE_8B;
  assign awburst     = BURST_INCR;
  assign awvalid     = awvalid_q;

  assign wid         = AXI_ID;
  assign wdata       = wbeat_data;
  assign wstrb       = wbeat_strb;
  assign wlast       = (state_q == ST_W) & beat_last;
  assign wvalid      = (state_q == ST_W) & wbeat_valid;
  assign wbeat_ready = (state_q == ST_W) & wready;

  assign bready      = bready_q;

  assign arlock      = '0;
  assign arcache     = '0;
  assign arprot      = '0;
  assign awlock      = '0;
  assign awcache     = '0;
  assign awprot      = '0;

  // IDs and the in-line offset of the request address are intentionally unused.
  logic unused_inputs;
  assign unused_inputs = ^{rid, bid, req_addr[OFF_W-1:0]};

endmodule
